mem_bus_arbiter: RTL and testbench

Shares a single Wishbone-style memory bus between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- Generates the stall requests that feed the pipeline controller: stallreq_if_o drives the controller's IF stall request; stallreq_mem_o drives its MEM stall request.
- Consumes the controller's stall vector and flush.
- Holds returned data until the consuming pipeline register advances.
- Enforces a bus timeout.

---
 rtl/mem_bus_arbiter_if.sv | 61 ++++++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Pipeline-side fetch/data ports, controller stall/flush and the shared
// Wishbone-style memory bus, bundled for the memory bus arbiter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;
  // controller
  logic [5:0]  stall_i;
  logic        flush_i;
  // fetch port
  logic        ibus_ce_i;
  logic [31:0] ibus_addr_i;
  logic [31:0] ibus_data_o;
  // data port
  logic        dbus_ce_i;
  logic        dbus_we_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_data_i;
  logic [31:0] dbus_data_o;
  // stall requests / error
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_err_o;
  // memory bus
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  // arbiter side
  modport master (
    input  stall_i, flush_i,
    input  ibus_ce_i, ibus_addr_i,
    output ibus_data_o,
    input  dbus_ce_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_data_i,
    output dbus_data_o,
    output stallreq_if_o, stallreq_mem_o, bus_err_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  // pipeline / memory side
  modport slave (
    output stall_i, flush_i,
    output ibus_ce_i, ibus_addr_i,
    input  ibus_data_o,
    output dbus_ce_i, dbus_we_i, dbus_sel_i, dbus_addr_i, dbus_data_i,
    input  dbus_data_o,
    input  stallreq_if_o, stallreq_mem_o, bus_err_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one Wishbone-style memory bus between the instruction-fetch and
// data-memory ports of the pipeline. Data port has priority, returned data
// is held until the consuming pipeline register advances, and a bus cycle
// with no acknowledge is aborted after TIMEOUT cycles.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_bus_arbiter_if.master     bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             ihold;
  logic             dhold;
  logic             discard;
  logic             bus_err;
  logic [31:0]      ibus_data;
  logic [31:0]      dbus_data;
  logic [31:0]      adr;
  logic [31:0]      dat;
  logic             we;
  logic [3:0]       sel;
  logic             cyc;
  logic             stb;

  logic             timed_out;
  logic             cycle_done;
  logic             drop_result;
  logic [31:0]      result;

  // A cycle ends on ack or when the counter reaches its last value; ack wins
  // a tie so real data is never replaced by the timeout zero.
  assign timed_out   = (timer == TIMEOUT_LAST);
  assign cycle_done  = bus.wb_ack_i | timed_out;
  // A flush in the completing cycle also kills the result.
  assign drop_result = discard | bus.flush_i;
  assign result      = bus.wb_ack_i ? bus.wb_dat_i : 32'h0;

  // Arbitration FSM, bus cycle registers, hold flags and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      ihold     <= 1'b0;
      dhold     <= 1'b0;
      discard   <= 1'b0;
      bus_err   <= 1'b0;
      ibus_data <= 32'h0;
      dbus_data <= 32'h0;
      adr       <= 32'h0;
      dat       <= 32'h0;
      we        <= 1'b0;
      sel       <= 4'h0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
    end else begin
      bus_err <= 1'b0;

      if (ihold && (!bus.stall_i[1] || bus.flush_i)) begin
        ihold <= 1'b0;
      end
      if (dhold && (!bus.stall_i[4] || bus.flush_i)) begin
        dhold <= 1'b0;
      end

      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (!bus.flush_i) begin
            if (bus.dbus_ce_i && !dhold) begin
              state <= D_BUSY;
              adr   <= bus.dbus_addr_i;
              dat   <= bus.dbus_data_i;
              we    <= bus.dbus_we_i;
              sel   <= bus.dbus_sel_i;
              cyc   <= 1'b1;
              stb   <= 1'b1;
              timer <= '0;
            end else if (bus.ibus_ce_i && !ihold) begin
              state <= I_BUSY;
              adr   <= bus.ibus_addr_i;
              dat   <= 32'h0;
              we    <= 1'b0;
              sel   <= 4'hF;
              cyc   <= 1'b1;
              stb   <= 1'b1;
              timer <= '0;
            end
          end
        end

        D_BUSY, I_BUSY: begin
          if (cycle_done) begin
            state   <= IDLE;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            discard <= 1'b0;
            if (!bus.wb_ack_i) begin
              bus_err <= 1'b1;
            end
            if (!drop_result) begin
              if (state == D_BUSY) begin
                dbus_data <= result;
                dhold     <= 1'b1;
              end else begin
                ibus_data <= result;
                ihold     <= 1'b1;
              end
            end
          end else begin
            timer <= timer + 1'b1;
            if (bus.flush_i) begin
              discard <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          cyc   <= 1'b0;
          stb   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stallreq_if_o  = bus.ibus_ce_i & ~ihold & ~bus.flush_i;
  assign bus.stallreq_mem_o = bus.dbus_ce_i & ~dhold & ~bus.flush_i;

  assign bus.ibus_data_o = ibus_data;
  assign bus.dbus_data_o = dbus_data;
  assign bus.bus_err_o   = bus_err;
  assign bus.wb_adr_o    = adr;
  assign bus.wb_dat_o    = dat;
  assign bus.wb_we_o     = we;
  assign bus.wb_sel_o    = sel;
  assign bus.wb_cyc_o    = cyc;
  assign bus.wb_stb_o    = stb;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with hand-computed expected values.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst              = 1'b1;
    bus.stall_i      = 6'h0;
    bus.flush_i      = 1'b0;
    bus.ibus_ce_i    = 1'b0;
    bus.ibus_addr_i  = 32'h0;
    bus.dbus_ce_i    = 1'b0;
    bus.dbus_we_i    = 1'b0;
    bus.dbus_sel_i   = 4'h0;
    bus.dbus_addr_i  = 32'h0;
    bus.dbus_data_i  = 32'h0;
    bus.wb_dat_i     = 32'h0;
    bus.wb_ack_i     = 1'b0;

    // reset state
    tick();
    tick();
    check_val("rst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("rst_stb", {31'h0, bus.wb_stb_o}, 32'h0);
    check_val("rst_adr", bus.wb_adr_o, 32'h0);
    check_val("rst_idata", bus.ibus_data_o, 32'h0);
    check_val("rst_ddata", bus.dbus_data_o, 32'h0);
    check_val("rst_err", {31'h0, bus.bus_err_o}, 32'h0);
    rst = 1'b0;
    tick();

    // 1: single fetch, ack in the third cycle of cyc
    bus.ibus_ce_i   = 1'b1;
    bus.ibus_addr_i = 32'h100;
    #1;
    check_val("t1_sreq_req", {31'h0, bus.stallreq_if_o}, 32'h1);
    tick();
    check_val("t1_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    check_val("t1_stb", {31'h0, bus.wb_stb_o}, 32'h1);
    check_val("t1_adr", bus.wb_adr_o, 32'h100);
    check_val("t1_sel", {28'h0, bus.wb_sel_o}, 32'hF);
    check_val("t1_we", {31'h0, bus.wb_we_o}, 32'h0);
    tick();
    check_val("t1_sreq_wait", {31'h0, bus.stallreq_if_o}, 32'h1);
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1357_9BDF;
    #1;
    check_val("t1_sreq_ack", {31'h0, bus.stallreq_if_o}, 32'h1);
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t1_cyc_done", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t1_idata", bus.ibus_data_o, 32'h1357_9BDF);
    check_val("t1_sreq_rel", {31'h0, bus.stallreq_if_o}, 32'h0);
    bus.ibus_ce_i = 1'b0;
    tick();

    // 2: simultaneous requests, data port first
    bus.ibus_ce_i   = 1'b1;
    bus.ibus_addr_i = 32'h300;
    bus.dbus_ce_i   = 1'b1;
    bus.dbus_we_i   = 1'b1;
    bus.dbus_sel_i  = 4'h3;
    bus.dbus_addr_i = 32'h200;
    bus.dbus_data_i = 32'hDEAD_BEEF;
    #1;
    check_val("t2_sreq_mem", {31'h0, bus.stallreq_mem_o}, 32'h1);
    check_val("t2_sreq_if", {31'h0, bus.stallreq_if_o}, 32'h1);
    tick();
    check_val("t2_d_adr", bus.wb_adr_o, 32'h200);
    check_val("t2_d_we", {31'h0, bus.wb_we_o}, 32'h1);
    check_val("t2_d_sel", {28'h0, bus.wb_sel_o}, 32'h3);
    check_val("t2_d_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0;
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t2_idle_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t2_sreq_mem_rel", {31'h0, bus.stallreq_mem_o}, 32'h0);
    check_val("t2_sreq_if_still", {31'h0, bus.stallreq_if_o}, 32'h1);
    bus.dbus_ce_i = 1'b0;
    bus.dbus_we_i = 1'b0;
    tick();
    check_val("t2_i_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    check_val("t2_i_adr", bus.wb_adr_o, 32'h300);
    check_val("t2_i_we", {31'h0, bus.wb_we_o}, 32'h0);
    check_val("t2_i_sel", {28'h0, bus.wb_sel_o}, 32'hF);
    check_val("t2_i_dat", bus.wb_dat_o, 32'h0);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hAAAA_5555;
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t2_idata", bus.ibus_data_o, 32'hAAAA_5555);
    check_val("t2_sreq_if_rel", {31'h0, bus.stallreq_if_o}, 32'h0);
    bus.ibus_ce_i = 1'b0;
    tick();

    // 3: flush one cycle into a fetch
    bus.ibus_ce_i   = 1'b1;
    bus.ibus_addr_i = 32'h400;
    tick();
    check_val("t3_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    bus.flush_i = 1'b1;
    #1;
    check_val("t3_sreq_flush", {31'h0, bus.stallreq_if_o}, 32'h0);
    tick();
    bus.flush_i     = 1'b0;
    bus.ibus_addr_i = 32'h20;
    check_val("t3_cyc_held", {31'h0, bus.wb_cyc_o}, 32'h1);
    check_val("t3_adr_held", bus.wb_adr_o, 32'h400);
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h5555_5555;
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t3_cyc_end", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t3_idata_kept", bus.ibus_data_o, 32'hAAAA_5555);
    check_val("t3_no_ihold", {31'h0, bus.stallreq_if_o}, 32'h1);
    tick();
    check_val("t3_refetch_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    check_val("t3_refetch_adr", bus.wb_adr_o, 32'h20);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h2020_2020;
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t3_refetch_data", bus.ibus_data_o, 32'h2020_2020);
    bus.ibus_ce_i = 1'b0;
    tick();

    // 4: good load, then a load that times out
    bus.dbus_ce_i   = 1'b1;
    bus.dbus_we_i   = 1'b0;
    bus.dbus_sel_i  = 4'hF;
    bus.dbus_addr_i = 32'h500;
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hCAFE_F00D;
    tick();
    bus.wb_ack_i  = 1'b0;
    check_val("t4_load_data", bus.dbus_data_o, 32'hCAFE_F00D);
    bus.dbus_ce_i = 1'b0;
    tick();
    bus.dbus_ce_i   = 1'b1;
    bus.dbus_addr_i = 32'h504;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      check_val("t4_cyc_wait", {30'h0, bus.wb_cyc_o, bus.bus_err_o}, 32'h2);
      tick();
    end
    check_val("t4_cyc_last", {30'h0, bus.wb_cyc_o, bus.bus_err_o}, 32'h2);
    tick();
    check_val("t4_cyc_drop", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t4_err_pulse", {31'h0, bus.bus_err_o}, 32'h1);
    check_val("t4_data_zero", bus.dbus_data_o, 32'h0);
    check_val("t4_sreq_mem", {31'h0, bus.stallreq_mem_o}, 32'h0);
    bus.dbus_ce_i = 1'b0;
    tick();
    check_val("t4_err_once", {31'h0, bus.bus_err_o}, 32'h0);

    // 5: fetch completes while IF/ID is held for 3 cycles
    bus.ibus_ce_i   = 1'b1;
    bus.ibus_addr_i = 32'h600;
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h6666_6666;
    bus.stall_i  = 6'b000010;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check_val("t5_idata_stable", bus.ibus_data_o, 32'h6666_6666);
      check_val("t5_sreq_held", {31'h0, bus.stallreq_if_o}, 32'h0);
      check_val("t5_no_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
      if (i < 2) tick();
    end
    bus.stall_i = 6'h0;
    tick();
    check_val("t5_ihold_clr", {31'h0, bus.stallreq_if_o}, 32'h1);
    check_val("t5_idata_after", bus.ibus_data_o, 32'h6666_6666);
    bus.ibus_ce_i = 1'b0;
    tick();

    // 6: reset in the middle of a data cycle
    bus.dbus_ce_i   = 1'b1;
    bus.dbus_addr_i = 32'h700;
    tick();
    check_val("t6_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_cyc_rst", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t6_stb_rst", {31'h0, bus.wb_stb_o}, 32'h0);
    check_val("t6_adr_rst", bus.wb_adr_o, 32'h0);
    check_val("t6_idata_rst", bus.ibus_data_o, 32'h0);
    check_val("t6_ddata_rst", bus.dbus_data_o, 32'h0);
    bus.dbus_ce_i = 1'b0;
    bus.wb_ack_i  = 1'b1;
    bus.wb_dat_i  = 32'h7777_7777;
    tick();
    bus.wb_ack_i = 1'b0;
    check_val("t6_late_ack_data", bus.dbus_data_o, 32'h0);
    check_val("t6_late_ack_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    check_val("t6_late_ack_err", {31'h0, bus.bus_err_o}, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
